// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: receiver state encoding and WS2812B timing constants
// shared by the LED driver and the receiver so TX and RX agree.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        SYNC,
        GAP,
        HIGH,
        LOW
    } rx_state_e;

    localparam int BITS_PER_PIXEL = 24;

    // Cycle counts at 50 MHz.
    localparam int T0H_CYC        = 20;
    localparam int T0L_CYC        = 43;
    localparam int T1H_CYC        = 40;
    localparam int T1L_CYC        = 23;
    localparam int BIT_THRESH_DEF = 30;
    localparam int MAX_HIGH_DEF   = 100;
    localparam int RES_CYC_DEF    = 2500;

endpackage

// File: rtl/ws2812b_sync_edge.sv
// ws2812b_sync_edge: 2-flop synchronizer for din with registered
// edge detection producing single-cycle rise/fall strobes.
module ws2812b_sync_edge (
    input  logic clk,
    input  logic res,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic din_d;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            meta  <= 1'b0;
            din_s <= 1'b0;
            din_d <= 1'b0;
        end else begin
            meta  <= din;
            din_s <= meta;
            din_d <= din_s;
        end
    end

    assign rise = din_s & ~din_d;
    assign fall = ~din_s & din_d;

endmodule

// File: rtl/ws2812b_receiver.sv
// ws2812b_receiver: decodes a WS2812B NRZ stream into 24-bit GRB pixels.
// Define WS2812B_RX_FORWARD_EN to pass pixels past LOCAL_PIXELS to dout.
module ws2812b_receiver
    import ws2812b_pkg::*;
#(
    parameter int BIT_THRESH = BIT_THRESH_DEF,
    parameter int MAX_HIGH   = MAX_HIGH_DEF,
    parameter int RES_CYC    = RES_CYC_DEF,
    parameter int IDX_W      = 8
`ifdef WS2812B_RX_FORWARD_EN
    ,
    parameter int LOCAL_PIXELS = 1
`endif
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      din,
    output logic [BITS_PER_PIXEL-1:0] pix_data,
    output logic                      pix_valid,
    output logic [IDX_W-1:0]          pix_idx,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      dout
);

    localparam int HW = $clog2(MAX_HIGH + 1);
    localparam int LW = $clog2(RES_CYC + 1);
    localparam int BW = $clog2(BITS_PER_PIXEL);

    localparam logic [HW-1:0]    H_MAX    = HW'(MAX_HIGH);
    localparam logic [HW-1:0]    H_THR    = HW'(BIT_THRESH);
    localparam logic [LW-1:0]    L_MAX    = LW'(RES_CYC);
    localparam logic [BW-1:0]    LAST_BIT = BW'(BITS_PER_PIXEL - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = '1;

    rx_state_e state, state_n;

    logic                      din_s, rise, fall, bit_val;
    logic [HW-1:0]             hcnt, hcnt_n;
    logic [LW-1:0]             lcnt, lcnt_n;
    logic [BW-1:0]             bitcnt, bitcnt_n;
    logic [BITS_PER_PIXEL-2:0] shreg, shreg_n;
    logic [BITS_PER_PIXEL-1:0] word, data_n;
    logic [IDX_W-1:0]          idx_n;
    logic                      valid_n, done_n, err_n;

    ws2812b_sync_edge u_sync (
        .clk   (clk),
        .res   (res),
        .din   (din),
        .din_s (din_s),
        .rise  (rise),
        .fall  (fall)
    );

    assign bit_val = (hcnt >= H_THR);
    assign word    = {shreg, bit_val};

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= SYNC;
            hcnt       <= '0;
            lcnt       <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_idx    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            hcnt       <= hcnt_n;
            lcnt       <= lcnt_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            pix_data   <= data_n;
            pix_valid  <= valid_n;
            pix_idx    <= idx_n;
            frame_done <= done_n;
            frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        hcnt_n   = hcnt;
        lcnt_n   = lcnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        data_n   = pix_data;
        valid_n  = 1'b0;
        idx_n    = pix_idx;
        done_n   = 1'b0;
        err_n    = 1'b0;
        // Index advances the cycle after its strobe and saturates.
        if (pix_valid && pix_idx != IDX_MAX) idx_n = pix_idx + 1'b1;
        unique case (state)
            SYNC: begin
                if (din_s) begin
                    lcnt_n = '0;
                end else if (lcnt >= L_MAX) begin
                    state_n  = GAP;
                    bitcnt_n = '0;
                    idx_n    = '0;
                end else begin
                    lcnt_n = lcnt + 1'b1;
                end
            end
            GAP: begin
                if (rise) begin
                    state_n  = HIGH;
                    bitcnt_n = '0;
                    hcnt_n   = HW'(1);
                end
            end
            HIGH: begin
                if (hcnt >= H_MAX) begin
                    err_n    = 1'b1;
                    state_n  = SYNC;
                    lcnt_n   = '0;
                    bitcnt_n = '0;
                end else if (fall) begin
                    state_n = LOW;
                    lcnt_n  = LW'(1);
                    shreg_n = word[BITS_PER_PIXEL-2:0];
                    if (bitcnt == LAST_BIT) begin
                        data_n   = word;
                        valid_n  = 1'b1;
                        bitcnt_n = '0;
                        err_n    = (pix_idx == IDX_MAX);
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            LOW: begin
                // Gap wins over a coincident rising edge.
                if (lcnt >= L_MAX) begin
                    state_n  = GAP;
                    done_n   = 1'b1;
                    err_n    = (bitcnt != '0);
                    bitcnt_n = '0;
                    idx_n    = '0;
                end else if (rise) begin
                    state_n = HIGH;
                    hcnt_n  = HW'(1);
                end else begin
                    lcnt_n = lcnt + 1'b1;
                end
            end
            default: state_n = SYNC;
        endcase
    end

`ifdef WS2812B_RX_FORWARD_EN
    logic fwd_en, fwd_go, start;

    assign fwd_go = (int'(pix_idx) >= LOCAL_PIXELS);
    assign start  = rise && (state == GAP ||
                             (state == LOW && lcnt < L_MAX));

    // Gate latched per bit so a forwarded pulse is never truncated.
    always_ff @(posedge clk or negedge res) begin
        if (!res) fwd_en <= 1'b0;
        else if (start) fwd_en <= fwd_go;
    end

    assign dout = din_s && (start ? fwd_go : (fwd_en && state == HIGH));
`else
    assign dout = 1'b0;
`endif

endmodule

// File: doc/ws2812b_receiver.md
Name: ws2812b_receiver

Overview:
- Decodes a WS2812B single-wire NRZ stream back into 24-bit GRB pixel words.
- Mirrors what a physical LED sees on its DIN pin. Used as the bench-side and loopback checker for the LED driver, and as an input stage for daisy-chained FPGA "virtual LEDs".
- Measures each high pulse to classify bits, groups bits into pixels, and detects the inter-frame reset gap.

Parameters:
- BIT_THRESH, 30: high-time threshold in clk cycles. Measured high ≥ BIT_THRESH decodes as 1, otherwise 0. At 50 MHz: T0H≈20, T1H≈40.
- MAX_HIGH, 100: high time reaching this count is a line fault.
- RES_CYC, 2500: low time (cycles) that constitutes a reset gap (50 us @ 50 MHz).
- IDX_W, 8: width of the pixel index.
- LOCAL_PIXELS, 1: pixels consumed locally before forwarding (forward feature only).

Ports:
- clk, in, 1: single system clock.
- res, in, 1: reset, asynchronous, active-low. Assertion clears all state; deassertion is used synchronously.
- din, in, 1: asynchronous WS2812B serial input.
- pix_data, out, 24: last completed pixel, GRB order, MSB first on the wire (bit 23 = G7).
- pix_valid, out, 1: one-cycle strobe; pix_data and pix_idx are valid.
- pix_idx, out, IDX_W: index of the pixel in pix_data within the current frame, starting at 0.
- frame_done, out, 1: one-cycle strobe at the end of a reset gap that followed ≥1 bit.
- frame_err, out, 1: one-cycle strobe on any fault (see below).
- dout, out, 1: forwarded stream (optional feature); 0 when the feature is absent.

Behaviour:
- Reset values: pix_data=0, pix_valid=0, pix_idx=0, frame_done=0, frame_err=0, dout=0, state=SYNC.
- din passes through a 2-flop synchronizer (din_s), followed by a registered edge detect. All latencies below are measured from the din pin.
- State SYNC: wait for din_s low for RES_CYC consecutive cycles, then go to GAP. Any high resets the low count. This guarantees no decode starts mid-frame.
- State GAP: idle. A rising edge clears the bit count and high counter, then goes to HIGH.
- State HIGH:
  - hcnt increments each cycle while high.
  - On falling edge: bit = (hcnt ≥ BIT_THRESH); shift into a 24-bit shift register, MSB first; go to LOW.
  - If hcnt reaches MAX_HIGH: frame_err pulses, go to SYNC; partial data is discarded.
- State LOW:
  - lcnt increments each cycle while low. A rising edge goes to HIGH with hcnt restarted.
  - If lcnt reaches RES_CYC: go to GAP and pulse frame_done.
  - Also pulse frame_err in the same cycle if bitcnt≠0 (partial pixel, discarded).
  - pix_idx and bitcnt reset to 0 on the transition to GAP.
- Pixel assembly:
  - On the 24th bit, pix_data is loaded and pix_valid pulses 3 clk after the din falling edge (2 sync + 1 register).
  - bitcnt returns to 0. pix_idx shows this pixel's index, then increments after the strobe.
- Index overflow: a pixel completing when the index is already 2^IDX_W−1 still strobes pix_valid with pix_idx = max. frame_err pulses and the index saturates (no wrap).
- Counters: hcnt saturates at MAX_HIGH; lcnt saturates at RES_CYC. Widths are $clog2(param+1).
- Simultaneous events: a glitch high of 0 cycles cannot occur post-sync. A rising edge in the same cycle lcnt hits RES_CYC gives the gap priority: frame ends and the edge is ignored until the next one.
- Reset mid-frame: all outputs return to their reset values and the state returns to SYNC; the in-flight frame is lost with no strobes.

Optional Feature:
- Macro: WS2812B_RX_FORWARD_EN.
- Defined:
  - dout = din_s while (pix_idx ≥ LOCAL_PIXELS, counted in completed pixels this frame) and state ∈ {HIGH, LOW}; otherwise 0.
  - Gating is evaluated at each rising edge so a bit is never truncated.
  - The reset gap is forwarded as low.
- Undefined: dout tied 0 and LOCAL_PIXELS is unused.

Decomposition:
- Package ws2812b_pkg holds:
  - the rx state enum (SYNC, GAP, HIGH, LOW);
  - BITS_PER_PIXEL=24;
  - default timing constants, shared with the driver so TX and RX agree.
- One sub-module, ws2812b_sync_edge: 2-flop synchronizer plus rise/fall strobes.

Test Plan:
- Reset, then din low 2500 cycles, then 24 bits with byte patterns 0xFF/0x00/0xA5 (1 = 40 high/23 low, 0 = 20 high/43 low), then 2500 low -> one pix_valid with pix_data=0xFF00A5, pix_idx=0; frame_done 1 cycle; no frame_err.
- 3 pixels back-to-back, then gap -> pix_idx 0,1,2 in order, each strobe 3 clk after the 24th falling edge; a new frame restarts at idx 0.
- High times of 29 and 30 cycles -> bits 0 and 1 respectively (threshold boundary).
- High held 100 cycles -> frame_err pulse, state SYNC; a following frame is ignored until 2500 low.
- 10 bits then gap -> frame_done and frame_err in the same cycle; no pix_valid.
- res asserted at bit 12 -> outputs 0 immediately (async); after release nothing decodes until a 2500-cycle gap. With WS2812B_RX_FORWARD_EN and LOCAL_PIXELS=1, 2 pixels -> dout silent for pixel 0 and a copy of pixel 1's waveform (delayed 2 clk).
